// File: rtl/ntt_pkg.sv
// Shared NTT constants and the bit-reverse controller state encoding.
package ntt_pkg;
  localparam int CYC_W     = 4;
  localparam int CHUNKS    = 1 << CYC_W;
  localparam int DP_LAT    = 2;
  localparam int PE_NUMBER = 16;
  localparam int PE_DEPTH  = CHUNKS;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} ctrl_state_e;
endpackage

// File: rtl/bit_reverse_ctrl_if.sv
// Handshake/status bundle between the coefficient source, the NTT controller and bit_reverse_ctrl.
interface bit_reverse_ctrl_if;
  logic                     start;
  logic                     busy;
  logic                     in_valid;
  logic                     in_ready;
  logic [ntt_pkg::CYC_W-1:0] cycle;
  logic                     out_valid;
  logic [ntt_pkg::CYC_W-1:0] out_chunk;
  logic                     done;

  modport master (
    output start, in_valid,
    input  busy, in_ready, cycle, out_valid, out_chunk, done
  );

  modport slave (
    input  start, in_valid,
    output busy, in_ready, cycle, out_valid, out_chunk, done
  );
endinterface

// File: rtl/bit_reverse_ctrl_delay.sv
// valid_delay_line: DEPTH-stage shift register of {valid, data} mirroring the datapath latency.
module valid_delay_line #(
  parameter int DEPTH = 2,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_vld,
  input  logic [W-1:0] i_data,
  output logic         o_vld,
  output logic [W-1:0] o_data
);
  logic [DEPTH:1]        r_vld_pipe;
  logic [DEPTH:1][W-1:0] r_data_pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_pipe  <= '0;
      r_data_pipe <= '0;
    end else begin
      r_vld_pipe[1]  <= i_vld;
      r_data_pipe[1] <= i_data;
      for (int s = 2; s <= DEPTH; s++) begin
        r_vld_pipe[s]  <= r_vld_pipe[s-1];
        r_data_pipe[s] <= r_data_pipe[s-1];
      end
    end
  end

  assign o_vld  = r_vld_pipe[DEPTH];
  assign o_data = r_data_pipe[DEPTH];
endmodule

// File: rtl/bit_reverse_ctrl.sv
// Bit-reverse stage sequencer: beat counter, IDLE/LOAD/DRAIN FSM, and output-valid tracking.
// Optional macro BITREV_CTRL_STALL_EN lets in_valid stall acceptance during LOAD.
module bit_reverse_ctrl
  import ntt_pkg::*;
(
  input logic               clk,
  input logic               reset,
  bit_reverse_ctrl_if.slave bus
);
  ctrl_state_e      r_state, w_state_nxt;
  logic [CYC_W-1:0] r_cnt;
  logic             r_busy;
  logic             w_accept;
  logic             w_last_beat;
  logic             w_tail_vld;
  logic [CYC_W-1:0] w_tail_idx;
  logic             w_done;

`ifdef BITREV_CTRL_STALL_EN
  assign w_accept = (r_state == LOAD) && bus.in_valid;
`else
  // Source guarantees a contiguous burst, so every LOAD cycle consumes a beat.
  logic w_unused_in_valid;
  assign w_unused_in_valid = bus.in_valid;
  assign w_accept          = (r_state == LOAD);
`endif

  assign w_last_beat = w_accept && (r_cnt == CYC_W'(CHUNKS - 1));
  assign w_done      = w_tail_vld && (w_tail_idx == CYC_W'(CHUNKS - 1));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (bus.start)   w_state_nxt = LOAD;
      LOAD:    if (w_last_beat) w_state_nxt = DRAIN;
      DRAIN:   if (w_done)      w_state_nxt = IDLE;
      default:                  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      // Counter wraps to 0 on the final beat, so it is already clear in DRAIN/IDLE.
      if (r_state == IDLE && bus.start) r_cnt <= '0;
      else if (w_accept)                r_cnt <= r_cnt + 1'b1;
    end
  end

  valid_delay_line #(.DEPTH(DP_LAT), .W(CYC_W)) u_vdl (
    .clk    (clk),
    .reset  (reset),
    .i_vld  (w_accept),
    .i_data (r_cnt),
    .o_vld  (w_tail_vld),
    .o_data (w_tail_idx)
  );

  assign bus.busy      = r_busy;
  assign bus.in_ready  = (r_state == LOAD);
  assign bus.cycle     = r_cnt;
  assign bus.out_valid = w_tail_vld;
  assign bus.out_chunk = w_tail_idx;
  assign bus.done      = w_done;
endmodule
